timer_peripheral: RTL and testbench

Memory-mapped peripheral block on the data-memory bus of the single-cycle MIPS CPU. It provides a reloading 32-bit timer whose overflow drives the `IRQ` input of the control unit, plus LED, switch, 7-segment and system-tick registers. It sits beside data memory: the datapath routes `MemRd`/`MemWr` accesses in the 0x4000_0000 page here, and its read data is muxed into the `MemtoReg` path.

---
 rtl/timer_peripheral.sv | 120 ++++++++++++
 tb/tb_timer_peripheral.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_peripheral.sv
// Reloading 32-bit timer with IRQ, LED, switch,
// 7-segment and system-tick registers on the data bus.
module timer_peripheral (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [7:0]  switch,
  output logic [31:0] rdata,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irqout
);

  localparam logic [29:0] A_TH   = 30'h1000_0000;
  localparam logic [29:0] A_TL   = 30'h1000_0001;
  localparam logic [29:0] A_TCON = 30'h1000_0002;
  localparam logic [29:0] A_LED  = 30'h1000_0003;
  localparam logic [29:0] A_SW   = 30'h1000_0004;
  localparam logic [29:0] A_DIGI = 30'h1000_0005;
  localparam logic [29:0] A_TICK = 30'h1000_0006;

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  led_q, led_d;
  logic [11:0] digi_q, digi_d;
  logic [31:0] tick_q, tick_d;

  logic [29:0] wa;
  logic        sel_th, sel_tl, sel_tcon;
  logic        sel_led, sel_sw, sel_digi;
  logic        sel_tick;
  logic        wr_tl, ovf;
  logic        unused_addr_bits;

  assign wa       = addr[31:2];
  assign unused_addr_bits = ^addr[1:0];
  assign sel_th   = (wa == A_TH);
  assign sel_tl   = (wa == A_TL);
  assign sel_tcon = (wa == A_TCON);
  assign sel_led  = (wa == A_LED);
  assign sel_sw   = (wa == A_SW);
  assign sel_digi = (wa == A_DIGI);
  assign sel_tick = (wa == A_TICK);

  // A TL store pre-empts both counting and overflow.
  assign wr_tl = MemWr & sel_tl;
  assign ovf   = tcon_q[0] & ~wr_tl & (&tl_q);

  assign led    = led_q;
  assign digi   = digi_q;
  assign irqout = tcon_q[2] & tcon_q[1];

  // Combinational read mux; zero when idle or unmapped.
  always_comb begin
    rdata = '0;
    if (MemRd) begin
      unique case (1'b1)
        sel_th:   rdata = th_q;
        sel_tl:   rdata = tl_q;
        sel_tcon: rdata = {29'd0, tcon_q};
        sel_led:  rdata = {24'd0, led_q};
        sel_sw:   rdata = {24'd0, switch};
        sel_digi: rdata = {20'd0, digi_q};
        sel_tick: rdata = tick_q;
        default:  rdata = '0;
      endcase
    end
  end

  // Next-state for bus writes, timer and systick.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    led_d  = led_q;
    digi_d = digi_q;
    tick_d = tick_q + 32'd1;

    if (wr_tl) begin
      tl_d = wdata;
    end else if (tcon_q[0]) begin
      tl_d = ovf ? th_q : tl_q + 32'd1;
    end

    if (MemWr & sel_tcon) begin
      tcon_d[1:0] = wdata[1:0];
      tcon_d[2]   = wdata[2] | (ovf & wdata[1]);
    end else if (ovf & tcon_q[1]) begin
      tcon_d[2] = 1'b1;
    end

    if (MemWr & sel_th)   th_d   = wdata;
    if (MemWr & sel_led)  led_d  = wdata[7:0];
    if (MemWr & sel_digi) digi_d = wdata[11:0];
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
      led_q  <= '0;
      digi_q <= '0;
      tick_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      led_q  <= led_d;
      digi_q <= digi_d;
      tick_q <= tick_d;
    end
  end

endmodule

// File: tb/tb_timer_peripheral.sv
// Directed testbench for timer_peripheral.
// Hand-computed expectations, one task per scenario.
module tb_timer_peripheral;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_SW   = 32'h4000_0010;
  localparam logic [31:0] A_DIGI = 32'h4000_0014;
  localparam logic [31:0] A_TICK = 32'h4000_0018;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        MemRd = 1'b0;
  logic        MemWr = 1'b0;
  logic [7:0]  switch = 8'h5A;
  logic [31:0] rdata;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irqout;

  int vecs = 0;
  int errs = 0;

  timer_peripheral dut (
    .clk(clk), .reset(reset), .addr(addr),
    .wdata(wdata), .MemRd(MemRd), .MemWr(MemWr),
    .switch(switch), .rdata(rdata), .led(led),
    .digi(digi), .irqout(irqout)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d);
    addr  = a;
    wdata = d;
    MemWr = 1'b1;
    @(posedge clk);
    #1;
    MemWr = 1'b0;
  endtask

  task automatic rd(input  logic [31:0] a,
                    output logic [31:0] d);
    addr  = a;
    MemRd = 1'b1;
    #1;
    d = rdata;
    MemRd = 1'b0;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic [31:0] a;
    #2;
    vecs++;
    if ({led, digi, irqout} !== 21'd0) begin
      errs++;
      $display("FAIL rst_out: got %h want 0",
               {led, digi, irqout});
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a = A_TH + 32'(i * 4);
      rd(a, d);
      vecs++;
      if (d !== ((a == A_SW) ? 32'h5A : 32'h0)) begin
        errs++;
        $display("FAIL rst_rd %h: got %h", a, d);
      end
    end
  endtask

  task automatic test_led_digi;
    logic [31:0] d;
    wr(A_LED, 32'hFFFF_FFA5);
    wr(A_DIGI, 32'h1234_5F3C);
    chk("led_out", {24'd0, led}, 32'hA5);
    chk("digi_out", {20'd0, digi}, 32'hF3C);
    rd(A_LED, d);
    chk("led_rd", d, 32'hA5);
    rd(A_DIGI, d);
    chk("digi_rd", d, 32'hF3C);
    rd(32'h4000_000F, d);
    chk("led_rd_lowbits", d, 32'hA5);
  endtask

  task automatic test_bus_edges;
    logic [31:0] d, s0, s1;
    wr(A_SW, 32'hFFFF_FFFF);
    wr(32'h4000_001C, 32'hFFFF_FFFF);
    rd(A_TH, d);
    chk("ign_th", d, 32'h0);
    rd(A_TL, d);
    chk("ign_tl", d, 32'h0);
    rd(A_TCON, d);
    chk("ign_tcon", d, 32'h0);
    rd(A_LED, d);
    chk("ign_led", d, 32'hA5);
    rd(A_DIGI, d);
    chk("ign_digi", d, 32'hF3C);
    rd(A_TICK, s0);
    wr(A_TICK, 32'h0);
    rd(A_TICK, s1);
    chk("tick_nowr", s1, s0 + 32'd1);
    rd(32'h4000_0020, d);
    chk("unmapped_rd", d, 32'h0);
    addr  = A_LED;
    MemRd = 1'b0;
    #1;
    chk("rd_idle", rdata, 32'h0);
    rd(A_TICK, s0);
    cyc(5);
    rd(A_TICK, s1);
    chk("tick_delta", s1 - s0, 32'd5);
    addr  = A_LED;
    wdata = 32'h3C;
    MemRd = 1'b1;
    MemWr = 1'b1;
    #1;
    chk("rdwr_pre", rdata, 32'hA5);
    @(posedge clk);
    #1;
    MemWr = 1'b0;
    chk("rdwr_post", rdata, 32'h3C);
    MemRd = 1'b0;
  endtask

  task automatic test_reload;
    logic [31:0] d;
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFC);
    wr(A_TCON, 32'h3);
    chk("rl_irq0", {31'd0, irqout}, 32'd0);
    cyc(3);
    rd(A_TL, d);
    chk("rl_tl_ff", d, 32'hFFFF_FFFF);
    chk("rl_irq3", {31'd0, irqout}, 32'd0);
    cyc(1);
    chk("rl_irq4", {31'd0, irqout}, 32'd1);
    rd(A_TL, d);
    chk("rl_tl_fc", d, 32'hFFFF_FFFC);
    rd(A_TCON, d);
    chk("rl_tcon7", d, 32'h7);
    cyc(3);
    rd(A_TL, d);
    chk("rl2_tl_ff", d, 32'hFFFF_FFFF);
    cyc(1);
    rd(A_TL, d);
    chk("rl2_tl_fc", d, 32'hFFFF_FFFC);
  endtask

  task automatic test_clear_mask;
    logic [31:0] d;
    wr(A_TCON, 32'h3);
    chk("clr_irq", {31'd0, irqout}, 32'd0);
    rd(A_TL, d);
    chk("clr_tl", d, 32'hFFFF_FFFD);
    cyc(2);
    chk("clr_irq_hold", {31'd0, irqout}, 32'd0);
    cyc(1);
    chk("clr_irq_again", {31'd0, irqout}, 32'd1);
    wr(A_TCON, 32'h1);
    cyc(3);
    rd(A_TL, d);
    chk("mask_tl", d, 32'hFFFF_FFFC);
    rd(A_TCON, d);
    chk("mask_tcon", d, 32'h1);
    chk("mask_irq", {31'd0, irqout}, 32'd0);
  endtask

  task automatic test_collisions;
    logic [31:0] d;
    wr(A_TCON, 32'h3);
    cyc(2);
    rd(A_TL, d);
    chk("col_pre_ff", d, 32'hFFFF_FFFF);
    wr(A_TL, 32'h10);
    rd(A_TL, d);
    chk("col_tl_wins", d, 32'h10);
    rd(A_TCON, d);
    chk("col_tl_tcon", d, 32'h3);
    chk("col_tl_irq", {31'd0, irqout}, 32'd0);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'h3);
    rd(A_TCON, d);
    chk("col_tcon7", d, 32'h7);
    chk("col_tcon_irq", {31'd0, irqout}, 32'd1);
    rd(A_TL, d);
    chk("col_tcon_tl", d, 32'hFFFF_FFFC);
  endtask

  task automatic test_reset_midrun;
    logic [31:0] d;
    #2;
    reset = 1'b0;
    #1;
    chk("mr_irq", {31'd0, irqout}, 32'd0);
    chk("mr_led", {24'd0, led}, 32'h0);
    chk("mr_digi", {20'd0, digi}, 32'h0);
    #1;
    reset = 1'b1;
    cyc(3);
    rd(A_TL, d);
    chk("mr_tl_hold", d, 32'h0);
    rd(A_TCON, d);
    chk("mr_tcon", d, 32'h0);
    rd(A_TH, d);
    chk("mr_th", d, 32'h0);
  endtask

  initial begin
    test_reset();
    test_led_digi();
    test_bus_edges();
    test_reload();
    test_clear_mask();
    test_collisions();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
